// File: rtl/game_pkg.sv
// Shared game-wide constants and types for the shooter object pools and renderer.
package game_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned X_W      = 10;
    localparam int unsigned Y_W      = 9;
    localparam int unsigned SHIP_W   = 16;
    localparam int unsigned BULLET_W = 4;
    localparam int unsigned BULLET_H = 8;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        SPAWN
    } pool_state_e;

endpackage

// File: rtl/free_slot_finder.sv
// Lowest-index free-slot priority encoder over an object pool's active mask.
module free_slot_finder #(
    parameter int unsigned N_SLOTS = 8
) (
    input  logic [N_SLOTS-1:0]         active_mask_i,
    output logic                       found_o,
    output logic [$clog2(N_SLOTS)-1:0] idx_o
);

    localparam int unsigned IW = $clog2(N_SLOTS);

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        // Scan from the top so the lowest free index is the last one written.
        for (int unsigned i = N_SLOTS; i > 0; i--) begin
            if (!active_mask_i[i-1]) begin
                found_o = 1'b1;
                idx_o   = IW'(i - 1);
            end
        end
    end

endmodule

// File: rtl/bullet_pool_ctrl.sv
// Player-bullet pool: fire-edge allocation, per-frame sequential sweep, kill and screen-exit retirement.
module bullet_pool_ctrl
    import game_pkg::*;
#(
    parameter int unsigned N_SLOTS  = 8,
    parameter int unsigned SPEED    = 5,
    parameter int unsigned X_OFF    = 8,
    parameter int unsigned COOLDOWN = 4
) (
    input  logic                       iVGA_CLK,
    input  logic                       iRST_n,
    input  logic                       frame_tick,
    input  logic                       fire,
    input  logic [X_W-1:0]             ship_x,
    input  logic [Y_W-1:0]             ship_y,
    input  logic                       kill_valid,
    input  logic [$clog2(N_SLOTS)-1:0] kill_idx,
    input  logic [$clog2(N_SLOTS)-1:0] rd_idx,
    output logic [X_W-1:0]             rd_x,
    output logic [Y_W-1:0]             rd_y,
    output logic                       rd_active,
    output logic [N_SLOTS-1:0]         active_mask,
    output logic                       spawned,
    output logic                       dropped,
    output logic                       overrun
);

    localparam int unsigned IW = $clog2(N_SLOTS);
    localparam int unsigned CW = $clog2(COOLDOWN + 1);
    localparam logic [Y_W-1:0] SPEED_Y  = Y_W'(SPEED);
    localparam logic [X_W-1:0] X_OFF_X  = X_W'(X_OFF);
    localparam logic [CW-1:0]  CD_LOAD  = CW'(COOLDOWN);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N_SLOTS - 1);

    pool_state_e                   state_q, state_d;
    logic [IW-1:0]                 cnt_q, cnt_d;
    logic [CW-1:0]                 cd_q, cd_d;
    logic                          pending_q, pending_d;
    logic                          fire_q;
    logic [N_SLOTS-1:0][X_W-1:0]   x_q, x_d;
    logic [N_SLOTS-1:0][Y_W-1:0]   y_q, y_d;
    logic [N_SLOTS-1:0]            act_q, act_d;
    logic                          spawned_q, spawned_d;
    logic                          dropped_q, dropped_d;
    logic                          overrun_q, overrun_d;
    logic [X_W-1:0]                rd_x_q;
    logic [Y_W-1:0]                rd_y_q;
    logic                          rd_active_q;
    logic                          free_found;
    logic [IW-1:0]                 free_idx;

    free_slot_finder #(.N_SLOTS(N_SLOTS)) u_free (
        .active_mask_i (act_q),
        .found_o       (free_found),
        .idx_o         (free_idx)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cd_d      = cd_q;
        pending_d = pending_q;
        x_d       = x_q;
        y_d       = y_q;
        act_d     = act_q;
        spawned_d = 1'b0;
        dropped_d = 1'b0;
        overrun_d = frame_tick && (state_q != IDLE);

        if (fire && !fire_q && (cd_q == '0)) pending_d = 1'b1;

        // Kill first; a same-cycle spawn below overrides it on the spawned slot.
        if (kill_valid) act_d[kill_idx] = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                    if (cd_q != '0) cd_d = cd_q - CW'(1);
                end else if (pending_q) begin
                    state_d = SPAWN;
                end
            end
            SWEEP: begin
                if (act_q[cnt_q] && !(kill_valid && (kill_idx == cnt_q))) begin
                    if (y_q[cnt_q] >= SPEED_Y) y_d[cnt_q] = y_q[cnt_q] - SPEED_Y;
                    else                       act_d[cnt_q] = 1'b0;
                end
                cnt_d = cnt_q + IW'(1);
                if (cnt_q == LAST_IDX) state_d = IDLE;
            end
            SPAWN: begin
                pending_d = 1'b0;
                state_d   = IDLE;
                if (free_found) begin
                    x_d[free_idx]   = ship_x + X_OFF_X;
                    y_d[free_idx]   = ship_y;
                    act_d[free_idx] = 1'b1;
                    spawned_d       = 1'b1;
                    cd_d            = CD_LOAD;
                end else begin
                    dropped_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cd_q        <= '0;
            pending_q   <= 1'b0;
            fire_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            act_q       <= '0;
            spawned_q   <= 1'b0;
            dropped_q   <= 1'b0;
            overrun_q   <= 1'b0;
            rd_x_q      <= '0;
            rd_y_q      <= '0;
            rd_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cd_q        <= cd_d;
            pending_q   <= pending_d;
            fire_q      <= fire;
            x_q         <= x_d;
            y_q         <= y_d;
            act_q       <= act_d;
            spawned_q   <= spawned_d;
            dropped_q   <= dropped_d;
            overrun_q   <= overrun_d;
            rd_x_q      <= x_q[rd_idx];
            rd_y_q      <= y_q[rd_idx];
            rd_active_q <= act_q[rd_idx];
        end
    end

    assign rd_x        = rd_x_q;
    assign rd_y        = rd_y_q;
    assign rd_active   = rd_active_q;
    assign active_mask = act_q;
    assign spawned     = spawned_q;
    assign dropped     = dropped_q;
    assign overrun     = overrun_q;

endmodule
